// File: rtl/fungen_pkg.sv
// Shared types and constants for the funGen playlist sequencer.
// Holds the FSM state encoding, the playlist entry layout and the waveform select codes.
package fungen_pkg;

  localparam int REP_W = 4;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, FIN} state_t;

  typedef struct packed {
    logic [1:0]       sel;
    logic [REP_W-1:0] reps;
  } seg_t;

  localparam logic [1:0] WAVE_0 = 2'b00;
  localparam logic [1:0] WAVE_1 = 2'b01;
  localparam logic [1:0] WAVE_2 = 2'b10;
  localparam logic [1:0] WAVE_3 = 2'b11;

endpackage

// File: rtl/fungen_period_ctr.sv
// Period/repeat counter for one playlist segment.
// seg_end flags the last clock of the reps-th generator period.
module fungen_period_ctr
  import fungen_pkg::*;
#(
  parameter int PERIOD_CLKS = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [REP_W-1:0] reps,
  output logic             seg_end
);

  localparam int PW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;

  logic [PW-1:0]    period_reg;
  logic [REP_W-1:0] rep_reg;
  logic             period_wrap;

  assign period_wrap = (period_reg == PW'(PERIOD_CLKS - 1));
  // reps is never 0 while enabled: zero-rep entries are skipped before PLAY.
  assign seg_end     = en && period_wrap && (rep_reg == reps - REP_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      period_reg <= '0;
      rep_reg    <= '0;
    end else if (en) begin
      if (period_wrap) begin
        period_reg <= '0;
        rep_reg    <= rep_reg + REP_W'(1);
      end else begin
        period_reg <= period_reg + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fungen_sequencer.sv
// Playlist sequencer driving funGen sel/rst: plays up to NUM_SEG {sel, reps} entries,
// re-phasing the generator at each segment boundary, with optional wrap-around looping.
module fungen_sequencer
  import fungen_pkg::*;
#(
  parameter int  NUM_SEG     = 4,
  parameter int  PERIOD_CLKS = 255,
  localparam int SEG_W       = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_sel,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic [SEG_W:0]   nseg,
  input  logic             start,
  input  logic             loop,
  input  logic             stop,
  output logic [1:0]       fg_sel,
  output logic             fg_rst,
  output logic [SEG_W-1:0] seg_idx,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  seg_t             table_reg [NUM_SEG];
  logic [SEG_W:0]   nseg_lat_reg, nseg_clamped;
  logic [SEG_W-1:0] seg_idx_reg, seg_next;
  logic [1:0]       fg_sel_reg, sel_next;
  logic             fg_rst_reg, busy_reg, done_reg;
  logic             wr_en, seg_end, is_last, accept_start;
  logic             ctr_clr, ctr_en;
  seg_t             cur_seg;

  assign wr_en        = cfg_we && !busy_reg;
  assign cur_seg      = table_reg[seg_idx_reg];
  assign is_last      = ({1'b0, seg_idx_reg} + (SEG_W + 1)'(1)) >= nseg_lat_reg;
  assign nseg_clamped = (nseg > (SEG_W + 1)'(NUM_SEG)) ? (SEG_W + 1)'(NUM_SEG) : nseg;
  assign accept_start = (state_reg == IDLE) && start && !stop && (nseg != '0);
  assign ctr_en       = (state_reg == PLAY) && !stop;
  assign ctr_clr      = (state_reg != PLAY) || stop;

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          table_reg[gi] <= '0;
        end else if (wr_en && (cfg_addr == SEG_W'(gi))) begin
          table_reg[gi] <= {cfg_sel, cfg_reps};
        end
      end
    end
  endgenerate

  fungen_period_ctr #(
    .PERIOD_CLKS(PERIOD_CLKS)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .reps   (cur_seg.reps),
    .seg_end(seg_end)
  );

  always_comb begin
    state_next = state_reg;
    seg_next   = seg_idx_reg;
    sel_next   = fg_sel_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (nseg != '0) begin
            state_next = LOAD;
            seg_next   = '0;
          end else begin
            state_next = FIN;
          end
        end
      end
      LOAD, PLAY: begin
        if ((state_reg == LOAD && cur_seg.reps == '0) || (state_reg == LOAD ? 1'b0 : seg_end)) begin
          if (!is_last) begin
            state_next = LOAD;
            seg_next   = seg_idx_reg + SEG_W'(1);
          end else if (loop) begin
            state_next = LOAD;
            seg_next   = '0;
          end else begin
            state_next = FIN;
          end
        end else if (state_reg == LOAD) begin
          state_next = PLAY;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop) begin
      state_next = IDLE;
      seg_next   = seg_idx_reg;
    end
    // A write landing on the same edge as start must be visible in the first LOAD.
    if (state_next == LOAD) begin
      sel_next = (wr_en && cfg_addr == seg_next) ? cfg_sel : table_reg[seg_next].sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      nseg_lat_reg <= '0;
      seg_idx_reg  <= '0;
      fg_sel_reg   <= WAVE_0;
      fg_rst_reg   <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      seg_idx_reg <= seg_next;
      fg_sel_reg  <= sel_next;
      fg_rst_reg  <= (state_next != PLAY);
      busy_reg    <= (state_next == LOAD) || (state_next == PLAY);
      done_reg    <= (state_next == FIN);
      if (accept_start) begin
        nseg_lat_reg <= nseg_clamped;
      end
    end
  end

  assign fg_sel  = fg_sel_reg;
  assign fg_rst  = fg_rst_reg;
  assign seg_idx = seg_idx_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_fungen_sequencer.sv
// Bench for fungen_sequencer with an 8-clock generator period.
// Expected behaviour is a cycle timeline expanded from the playlist contents.
module tb_fungen_sequencer;

  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [1:0] cfg_sel = '0;
  logic [3:0] cfg_reps = '0;
  logic [2:0] nseg = '0;
  logic       start = 1'b0;
  logic       loop = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] fg_sel;
  logic       fg_rst;
  logic [1:0] seg_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;

  logic [1:0] ent_sel  [4];
  int         ent_reps [4];
  logic [1:0] model_sel = 2'd0;
  logic [1:0] model_idx = 2'd0;
  logic [6:0] exp_q [$];

  fungen_sequencer #(
    .NUM_SEG    (4),
    .PERIOD_CLKS(P)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_sel (cfg_sel),
    .cfg_reps(cfg_reps),
    .nseg    (nseg),
    .start   (start),
    .loop    (loop),
    .stop    (stop),
    .fg_sel  (fg_sel),
    .fg_rst  (fg_rst),
    .seg_idx (seg_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Observation vector: {busy, fg_rst, done, fg_sel, seg_idx}
  function automatic logic [6:0] mk(input logic b, input logic r, input logic d,
                                    input logic [1:0] s, input logic [1:0] ix);
    return {b, r, d, s, ix};
  endfunction

  function automatic logic [6:0] obs();
    return {busy, fg_rst, done, fg_sel, seg_idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each entry: one LOAD cycle, then reps*P playing cycles; then one FIN and back to idle.
  task automatic build_trace(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, ent_sel[i], 2'(i)));
      for (int k = 0; k < ent_reps[i] * P; k++)
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, ent_sel[i], 2'(i)));
      model_sel = ent_sel[i];
      model_idx = 2'(i);
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, model_sel, model_idx));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, model_sel, model_idx));
  endtask

  task automatic write_table();
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i); cfg_sel = ent_sel[i]; cfg_reps = 4'(ent_reps[i]);
      tick();
    end
    cfg_we = 1'b0;
  endtask

  // mode 0: plain start; 1: entry-0 write in the start cycle; 2: writes while busy
  task automatic play_and_compare(input string name, input int n, input int mode);
    int errs = 0;
    nseg = 3'(n);
    start = 1'b1;
    cfg_we = (mode == 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
      checks++;
      if (obs() !== exp_q[i]) begin
        errs++;
        if (errs < 4)
          $display("FAIL %s cycle %0d: got {busy,rst,done,sel,idx}=%b required %b",
                   name, i + 1, obs(), exp_q[i]);
      end else begin
        passed++;
      end
      if (mode == 2 && i < 3) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_sel = 2'd3; cfg_reps = 4'd2;
      end
    end
    $display("playlist %s nseg=%0d cycles=%0d errors=%0d", name, n, exp_q.size(), errs);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (fg_rst !== 1'b1) $display("FAIL reset_fg_rst: got %b required 1", fg_rst); else passed++;
    checks++; if (fg_sel !== 2'd0) $display("FAIL reset_fg_sel: got %0d required 0", fg_sel); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else passed++;
    checks++; if (seg_idx !== 2'd0) $display("FAIL reset_seg_idx: got %0d required 0", seg_idx); else passed++;
    model_sel = 2'd0; model_idx = 2'd0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    ent_sel = '{2'd0, 2'd1, 2'd0, 2'd0}; ent_reps = '{2, 1, 0, 0};
    write_table();
    build_trace(2);
    checks++;
    if (exp_q.size() != 28 || exp_q[26][4] !== 1'b1)
      $display("FAIL basic_model_done_pos: got size %0d required 28", exp_q.size());
    else passed++;
    play_and_compare("basic", 2, 0);
  endtask

  task automatic test_skip();
    ent_sel = '{2'd2, 2'd3, 2'd0, 2'd0}; ent_reps = '{0, 1, 0, 0};
    write_table();
    build_trace(2);
    play_and_compare("skip", 2, 0);
  endtask

  task automatic test_loop();
    int dones = 0;
    ent_sel[0] = 2'd1; ent_reps[0] = 1;
    write_table();
    nseg = 3'd1; loop = 1'b1; start = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < P + 1; c++) begin
        tick();
        start = 1'b0;
        checks++;
        if (obs() !== mk(1'b1, c == 0, 1'b0, 2'd1, 2'd0))
          $display("FAIL loop_pass%0d_cycle%0d: got %b required %b", it, c, obs(),
                   mk(1'b1, c == 0, 1'b0, 2'd1, 2'd0));
        else passed++;
      end
    end
    for (int c = 0; c < P + 3; c++) begin
      tick();
      if (c == 3) loop = 1'b0;
      if (done === 1'b1) dones++;
      if (c == P + 1) begin
        checks++;
        if (obs() !== mk(1'b0, 1'b1, 1'b1, 2'd1, 2'd0))
          $display("FAIL loop_final_fin: got %b required %b", obs(), mk(1'b0, 1'b1, 1'b1, 2'd1, 2'd0));
        else passed++;
      end
    end
    checks++;
    if (dones != 1) $display("FAIL loop_done_count: got %0d required 1", dones); else passed++;
    model_sel = 2'd1; model_idx = 2'd0;
    $display("loop run done_count=%0d", dones);
  endtask

  task automatic test_stop();
    ent_sel[0] = 2'd2; ent_reps[0] = 3;
    write_table();
    nseg = 3'd1; start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (obs() !== mk(1'b1, 1'b0, 1'b0, 2'd2, 2'd0))
      $display("FAIL stop_pre_play: got %b required %b", obs(), mk(1'b1, 1'b0, 1'b0, 2'd2, 2'd0));
    else passed++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs() !== mk(1'b0, 1'b1, 1'b0, 2'd2, 2'd0))
        $display("FAIL stop_idle_%0d: got %b required %b", c, obs(), mk(1'b0, 1'b1, 1'b0, 2'd2, 2'd0));
      else passed++;
      tick();
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs() !== mk(1'b0, 1'b1, 1'b0, 2'd2, 2'd0))
        $display("FAIL start_stop_idle_%0d: got %b required %b", c, obs(), mk(1'b0, 1'b1, 1'b0, 2'd2, 2'd0));
      else passed++;
      tick();
    end
    model_sel = 2'd2; model_idx = 2'd0;
    $display("stop and start+stop collision checked");
  endtask

  task automatic test_write_start();
    ent_sel[0] = 2'd3; ent_reps[0] = 1;
    cfg_addr = 2'd0; cfg_sel = 2'd3; cfg_reps = 4'd1;
    build_trace(1);
    play_and_compare("write_with_start", 1, 1);
  endtask

  task automatic test_cfg_guard();
    ent_sel = '{2'd1, 2'd2, 2'd0, 2'd0}; ent_reps = '{1, 1, 0, 0};
    write_table();
    build_trace(2);
    play_and_compare("guard_first", 2, 2);
    build_trace(2);
    play_and_compare("guard_rerun", 2, 0);
    nseg = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== mk(1'b0, 1'b1, 1'b1, model_sel, model_idx))
      $display("FAIL nseg0_fin: got %b required %b", obs(), mk(1'b0, 1'b1, 1'b1, model_sel, model_idx));
    else passed++;
    tick();
    checks++;
    if (obs() !== mk(1'b0, 1'b1, 1'b0, model_sel, model_idx))
      $display("FAIL nseg0_idle: got %b required %b", obs(), mk(1'b0, 1'b1, 1'b0, model_sel, model_idx));
    else passed++;
    $display("nseg=0 start checked");
  endtask

  task automatic test_reset_mid();
    ent_sel = '{2'd3, 2'd1, 2'd2, 2'd1}; ent_reps = '{2, 2, 2, 2};
    write_table();
    nseg = 3'd4; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs() !== mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0))
      $display("FAIL reset_mid: got %b required %b", obs(), mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    else passed++;
    model_sel = 2'd0; model_idx = 2'd0;
    ent_sel = '{2'd0, 2'd0, 2'd0, 2'd0}; ent_reps = '{0, 0, 0, 0};
    build_trace(4);
    play_and_compare("after_reset_cleared_table", 4, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      int n;
      for (int i = 0; i < 4; i++) begin
        ent_sel[i]  = 2'($urandom_range(0, 3));
        ent_reps[i] = int'($urandom_range(0, 3));
      end
      n = int'($urandom_range(0, 4));
      write_table();
      build_trace(n);
      play_and_compare($sformatf("random%0d", r), n, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_loop();
    test_stop();
    test_write_start();
    test_cfg_guard();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
